// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for lock with
// bounded retries, and qualifies clk_good after continuous stable lock.
module pll_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned STABLE_CYCLES  = 100000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clkin_100m,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       clk_good,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam logic [31:0] RST_LAST = 32'(PLL_RST_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] STB_LAST = 32'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RTY_MAX  = 4'(MAX_RETRIES);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic        sync1;
  logic        lock_s;
  logic [3:0]  retry_nxt;
  logic [7:0]  lost_nxt;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lost_nxt  = lost_cnt;
    unique case (state)
      ST_ASSERT: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_nxt = ST_STABLE;
        end else if (cnt == TMO_LAST) begin
          if (retry_cnt == RTY_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            retry_nxt = retry_cnt + 4'd1;
            state_nxt = ST_ASSERT;
          end
        end
      end
      ST_STABLE: begin
        // A drop in the terminal cycle must not reach RUN
        if (!lock_s) state_nxt = ST_WAIT;
        else if (cnt == STB_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          if (lost_cnt != 8'hff) lost_nxt = lost_cnt + 8'd1;
          retry_nxt = 4'd0;
          state_nxt = ST_ASSERT;
        end
      end
      ST_FAIL: state_nxt = ST_FAIL;
      default: state_nxt = ST_ASSERT;
    endcase
  end

  always_ff @(posedge clkin_100m) begin
    if (reset) begin
      sync1     <= 1'b0;
      lock_s    <= 1'b0;
      state     <= ST_ASSERT;
      cnt       <= '0;
      pll_reset <= 1'b1;
      clk_good  <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
    end else begin
      sync1     <= pll_locked;
      lock_s    <= sync1;
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + 32'd1;
      pll_reset <= (state_nxt == ST_ASSERT);
      clk_good  <= (state_nxt == ST_RUN);
      fail      <= (state_nxt == ST_FAIL);
      retry_cnt <= retry_nxt;
      lost_cnt  <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: acquisition, chatter, loss,
// saturation, timeout-to-failure and mid-operation reset.
module tb_pll_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       pll_reset;
  logic       clk_good;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;
  int lost_exp = 0;

  pll_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(50),
    .STABLE_CYCLES(20),
    .MAX_RETRIES(2)
  ) dut (
    .clkin_100m(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .pll_reset(pll_reset),
    .clk_good(clk_good),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_prst"}, 32'(pll_reset), 1);
    chk({tag, "_good"}, 32'(clk_good), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_rty"}, 32'(retry_cnt), 0);
    chk({tag, "_lost"}, 32'(lost_cnt), 0);
  endtask

  task automatic wait_good(input string tag, input int maxc);
    int n = 0;
    while (!clk_good && n < maxc) begin
      step(1);
      n++;
    end
    chk(tag, 32'(clk_good), 1);
  endtask

  // lock raised at current negedge: good appears after exactly 23 negedges
  task automatic lock_to_good(input string tag);
    for (int i = 0; i < 22; i++) begin
      step(1);
      chk({tag, "_nogood"}, 32'(clk_good), 0);
      chk({tag, "_noprst"}, 32'(pll_reset), 0);
    end
    step(1);
    chk({tag, "_good"}, 32'(clk_good), 1);
  endtask

  task automatic pulse4(input string tag);
    step(3);
    chk({tag, "_hi"}, 32'(pll_reset), 1);
    step(1);
    chk({tag, "_lo"}, 32'(pll_reset), 0);
  endtask

  initial begin
    reset = 1'b1;
    pll_locked = 1'b0;
    step(3);
    chk_rst("rst0");

    // normal acquisition
    reset = 1'b0;
    pulse4("t1_pulse");
    step(10);
    pll_locked = 1'b1;
    lock_to_good("t1");
    chk("t1_rty", 32'(retry_cnt), 0);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_lost", 32'(lost_cnt), 0);

    // lock loss in RUN, then chatter during reacquisition
    step(5);
    pll_locked = 1'b0;
    step(2);
    chk("t4_good_hold", 32'(clk_good), 1);
    chk("t4_prst_hold", 32'(pll_reset), 0);
    step(1);
    chk("t4_good_fall", 32'(clk_good), 0);
    chk("t4_prst_rise", 32'(pll_reset), 1);
    chk("t4_lost", 32'(lost_cnt), 1);
    chk("t4_rty", 32'(retry_cnt), 0);
    lost_exp = 1;
    pulse4("t4_pulse");
    pll_locked = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("t3_hold_good", 32'(clk_good), 0);
      chk("t3_hold_prst", 32'(pll_reset), 0);
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t3_drop_good", 32'(clk_good), 0);
      chk("t3_drop_prst", 32'(pll_reset), 0);
    end
    pll_locked = 1'b1;
    lock_to_good("t3");
    chk("t3_rty", 32'(retry_cnt), 0);

    // lost_cnt saturation
    for (int n = 0; n < 260; n++) begin
      pll_locked = 1'b0;
      step(3);
      chk("t5_loss", 32'(clk_good), 0);
      pll_locked = 1'b1;
      wait_good("t5_reacq", 60);
      lost_exp = (lost_exp < 255) ? lost_exp + 1 : 255;
      chk("t5_lost", 32'(lost_cnt), 32'(lost_exp));
    end
    chk("t5_sat", 32'(lost_cnt), 255);

    // reset while in STABLE
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(4);
    chk("t6_prst_lo", 32'(pll_reset), 0);
    step(5);
    chk("t6_stable_good", 32'(clk_good), 0);
    reset = 1'b1;
    step(1);
    chk_rst("t6_stable");
    reset = 1'b0;
    pll_locked = 1'b0;

    // timeouts and retries to failure
    pulse4("t2_p0");
    chk("t2_rty0", 32'(retry_cnt), 0);
    for (int r = 1; r <= 2; r++) begin
      step(49);
      chk("t2_low", 32'(pll_reset), 0);
      chk("t2_nogood", 32'(clk_good), 0);
      step(1);
      chk("t2_rise", 32'(pll_reset), 1);
      chk("t2_rty", 32'(retry_cnt), 32'(r));
      pulse4("t2_p");
    end
    step(49);
    chk("t2_prefail", 32'(fail), 0);
    step(1);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_fail_prst", 32'(pll_reset), 0);
    chk("t2_fail_rty", 32'(retry_cnt), 2);
    for (int i = 0; i < 10; i++) begin
      step(100);
      chk("t2_sticky", 32'(fail), 1);
      chk("t2_sticky_good", 32'(clk_good), 0);
      chk("t2_sticky_prst", 32'(pll_reset), 0);
    end

    // reset while in FAIL, then clean restart
    reset = 1'b1;
    step(1);
    chk_rst("t6_fail");
    reset = 1'b0;
    pulse4("t6_restart");
    pll_locked = 1'b1;
    lock_to_good("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Supervises the board PLL from the free-running 100 MHz input clock. Drives the PLL reset input, waits for lock with a timeout, retries a bounded number of times, and declares the clock good only after lock has been continuously stable. Sits beside the PLL wrapper and sources the lock-qualified `clk_good` that downstream reset generators consume in place of raw `locked`.

## Interface
- `PLL_RST_CYCLES`, default 16: width of each `pll_reset` pulse, in clkin cycles (≥1).
- `LOCK_TIMEOUT`, default 1000000: cycles to wait for lock after a reset pulse (≥2).
- `STABLE_CYCLES`, default 100000: cycles synchronized lock must stay high before `clk_good` (≥1).
- `MAX_RETRIES`, default 3: extra reset pulses allowed before declaring failure (0..15).
- `clkin_100m`  in  1: free-running reference clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `pll_locked`  in  1: PLL lock status, asynchronous to `clkin_100m`.
- `pll_reset`  out  1: PLL reset request, active-high.
- `clk_good`  out  1: PLL output clock qualified stable.
- `fail`  out  1: retries exhausted; sticky until `reset`.
- `retry_cnt`  out  4: reset pulses issued after the first pulse in the current acquisition.
- `lost_cnt`  out  8: lock-loss events seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to `lock_s`. Only `lock_s` is used.
- One 32-bit cycle counter `cnt`. It clears on every state change.
- All outputs are registered and decoded from the next state.
- Reset values: state ASSERT, `cnt`=0, `pll_reset`=1, `clk_good`=0, `fail`=0, `retry_cnt`=0, `lost_cnt`=0, synchronizer flops=0.
- ASSERT:
  - `pll_reset`=1.
  - When `cnt`=PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_reset`=0.
  - If `lock_s`=1, go to STABLE.
  - Else, when `cnt`=LOCK_TIMEOUT-1: if `retry_cnt`=MAX_RETRIES go to FAIL, otherwise increment `retry_cnt` and go to ASSERT.
- STABLE:
  - If `lock_s`=0, go to WAIT_LOCK. The timeout restarts and `retry_cnt` is unchanged.
  - When `cnt`=STABLE_CYCLES-1 with `lock_s`=1, go to RUN.
- RUN:
  - `clk_good`=1.
  - If `lock_s`=0: `lost_cnt` increments (saturating), `retry_cnt` clears to 0, go to ASSERT.
- FAIL:
  - `pll_reset`=0, `clk_good`=0, `fail`=1.
  - Terminal; only `reset` exits.
- Simultaneous events:
  - In STABLE, `lock_s`=0 in the terminal cycle takes priority; the block goes to WAIT_LOCK, not RUN.
  - In WAIT_LOCK, `lock_s`=1 in the timeout cycle takes priority; the block goes to STABLE.
- `reset` asserted in any state wins over every transition. On the next edge all registers take their reset values, so `pll_reset` rises immediately after the reset edge.
- `lock_s` glitches shorter than one clkin cycle may be missed. This is acceptable; no filtering beyond the synchronizer.

## Timing
- Lock path latency: `pll_locked` rising before edge k gives `lock_s`=1 after edge k+1.
  - State enters STABLE at edge k+2.
  - `clk_good` rises at edge k+2+STABLE_CYCLES.
- First pulse: after `reset` is released, `pll_reset` stays high for exactly PLL_RST_CYCLES cycles.
- Timeout: with lock never seen, the time from `pll_reset` falling to the next `pll_reset` rising is exactly LOCK_TIMEOUT cycles.
- Lock loss: from `pll_locked` falling before edge k, `clk_good` falls and `pll_reset` rises together at edge k+2.
- Failure: `fail` rises at the same edge that would otherwise have started retry MAX_RETRIES+1.

## Test plan
Test parameters unless noted: PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=20, MAX_RETRIES=2.

1. Normal acquisition.
   - Stimulus: release `reset`; raise `pll_locked` 10 cycles after `pll_reset` falls.
   - Required: `pll_reset` high for 4 cycles; `clk_good` rises 22 cycles after `pll_locked` rises; `retry_cnt`=0; `fail`=0.
2. Timeout and retries to failure.
   - Stimulus: `pll_locked` held at 0.
   - Required: three `pll_reset` pulses of 4 cycles, each separated by 50 low cycles; `retry_cnt` goes 0, 1, 2; `fail`=1 at the third timeout and stays there for 1000 cycles; `clk_good`=0 throughout.
3. Lock chatter in STABLE.
   - Stimulus: lock for 15 cycles, drop for 3 cycles, relock.
   - Required: no `clk_good` during chatter; `clk_good` rises 22 cycles after the relock edge; no extra `pll_reset`.
4. Lock loss in RUN.
   - Stimulus: drop `pll_locked` once while in RUN.
   - Required: `clk_good` falls and `pll_reset` rises 2 edges later; `lost_cnt`=1; `retry_cnt`=0; reacquisition completes normally.
5. `lost_cnt` saturation.
   - Stimulus: 260 lock-loss/reacquire cycles.
   - Required: `lost_cnt`=255.
6. Reset mid-operation.
   - Stimulus: assert `reset` for one cycle in STABLE, and separately in FAIL.
   - Required: next edge gives `pll_reset`=1, `fail`=0, `clk_good`=0, and both counters=0; acquisition restarts from ASSERT.
